// File: rtl/sequence_player_module.sv
// sequence_player_module
// Fetches values (1..4) from a random-number generator over a trigger/ready
// handshake, appends them to a sequence buffer, and plays the buffer back as
// one-hot LED pulses with fixed on/off timing. A combinational read port lets
// the input checker look up any stored entry.
//
// Optional feature macro: SEQ_REQ_TIMEOUT_EN
//   defined   : WAIT gives up after REQ_TIMEOUT cycles without ready (o_err set)
//   undefined : WAIT holds until ready, i_clear or i_enable low
//
// Generator handshake: o_gen_trigger is a single-cycle request. The first
// cycle in which i_gen_ready is high, from the trigger cycle onward, carries
// the value in i_gen_value. That value is consumed, and i_gen_ready is
// ignored outside REQ/WAIT.
module sequence_player_module #(
  parameter int MAX_LEN     = 32,
  parameter int ON_CYCLES   = 50,
  parameter int OFF_CYCLES  = 25,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic                         i_clear,
  input  logic                         i_add,
  input  logic                         i_play,
  output logic                         o_gen_trigger,
  input  logic                         i_gen_ready,
  input  logic [2:0]                   i_gen_value,
  output logic [3:0]                   o_led,
  output logic                         o_busy,
  output logic                         o_add_done,
  output logic                         o_play_done,
  output logic                         o_full,
  output logic [$clog2(MAX_LEN+1)-1:0] o_len,
  output logic                         o_err,
  input  logic [$clog2(MAX_LEN)-1:0]   i_rd_idx,
  output logic [2:0]                   o_rd_value,
  output logic [2:0]                   o_dbg_state
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ?
                           ((ON_CYCLES > REQ_TIMEOUT) ? ON_CYCLES : REQ_TIMEOUT) :
                           ((OFF_CYCLES > REQ_TIMEOUT) ? OFF_CYCLES : REQ_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    PLAY_ON  = 3'd3,
    PLAY_OFF = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [LEN_W-1:0]   r_len;
  logic               r_err;
  logic               r_gen_trigger;
  logic [3:0]         r_led;
  logic               r_busy;
  logic               r_add_done;
  logic               r_play_done;
  logic [2:0]         r_buf [MAX_LEN];

  logic               w_full;
  logic               w_store;
  logic               w_err_set;
  logic               w_add_done;
  logic               w_play_done;
  logic               w_val_ok;
  logic               w_last;

  function automatic logic [3:0] one_hot(input logic [2:0] v);
    case (v)
      3'd1:    one_hot = 4'b0001;
      3'd2:    one_hot = 4'b0010;
      3'd3:    one_hot = 4'b0100;
      3'd4:    one_hot = 4'b1000;
      default: one_hot = 4'b0000;
    endcase
  endfunction

  assign w_full   = (r_len == LEN_W'(MAX_LEN));
  assign w_val_ok = (i_gen_value >= 3'd1) && (i_gen_value <= 3'd4);
  assign w_last   = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));

  // Next-state, counters and one-cycle event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_store     = 1'b0;
    w_err_set   = 1'b0;
    w_add_done  = 1'b0;
    w_play_done = 1'b0;
    if (i_clear || !i_enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_add) begin
            if (w_full) begin
              w_err_set = 1'b1;
            end else begin
              w_state_nxt = REQ;
            end
          end else if (i_play) begin
            if (r_len == '0) begin
              w_play_done = 1'b1;
            end else begin
              w_idx_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = PLAY_ON;
            end
          end
        end
        REQ, WAIT: begin
          if (i_gen_ready) begin
            w_state_nxt = IDLE;
            if (w_val_ok) begin
              w_store    = 1'b1;
              w_add_done = 1'b1;
            end else begin
              w_err_set = 1'b1;
            end
          end else if (r_state == REQ) begin
            // The REQ cycle is the first cycle of the wait window.
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
`ifdef SEQ_REQ_TIMEOUT_EN
            if (r_cnt == CNT_W'(REQ_TIMEOUT - 1)) begin
              w_state_nxt = IDLE;
              w_err_set   = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`else
            w_state_nxt = WAIT;
`endif
          end
        end
        PLAY_ON: begin
          if (r_cnt == CNT_W'(ON_CYCLES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = PLAY_OFF;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        PLAY_OFF: begin
          if (r_cnt == CNT_W'(OFF_CYCLES - 1)) begin
            w_cnt_nxt = '0;
            if (w_last) begin
              w_state_nxt = IDLE;
              w_play_done = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_state_nxt = PLAY_ON;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters, length, sticky error and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_err         <= 1'b0;
      r_gen_trigger <= 1'b0;
      r_led         <= 4'b0000;
      r_busy        <= 1'b0;
      r_add_done    <= 1'b0;
      r_play_done   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_gen_trigger <= (w_state_nxt == REQ);
      r_busy        <= (w_state_nxt != IDLE);
      r_add_done    <= w_add_done;
      r_play_done   <= w_play_done;
      r_led         <= (w_state_nxt == PLAY_ON) ? one_hot(r_buf[w_idx_nxt]) : 4'b0000;
      if (i_clear) begin
        r_len <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_store)   r_len <= r_len + LEN_W'(1);
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  // Sequence storage; contents need no reset because o_len gates every read.
  always_ff @(posedge i_clk) begin
    if (w_store) r_buf[r_len[IDX_W-1:0]] <= i_gen_value;
  end

  assign o_gen_trigger = r_gen_trigger;
  assign o_led         = r_led;
  assign o_busy        = r_busy;
  assign o_add_done    = r_add_done;
  assign o_play_done   = r_play_done;
  assign o_full        = w_full;
  assign o_len         = r_len;
  assign o_err         = r_err;
  assign o_rd_value    = (LEN_W'(i_rd_idx) < r_len) ? r_buf[i_rd_idx] : 3'd0;
  assign o_dbg_state   = r_state;

endmodule
